video_cfg_scheduler: RTL and testbench

//  Frame-synchronous configuration scheduler for the video core chain. Buffers host register

---
 rtl/video_cfg_scheduler_if.sv | 47 ++++
 rtl/video_cfg_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_video_cfg_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_cfg_scheduler_if.sv
// Host register-write channel into the video configuration scheduler.
//
// Purpose
//   Groups the host-side valid/ready write bus (target core, register address,
//   write data) so the scheduler and its host can be connected as one bundle.
//
// Signals
//   host_valid  master -> slave  write request
//   host_ready  slave  -> master scheduler can accept this cycle
//   host_core   master -> slave  target core index, $clog2(NCORE) bits
//   host_addr   master -> slave  target register address, AW bits
//   host_data   master -> slave  write data, DW bits
//
// Modports
//   master  the host issuing writes
//   slave   the scheduler accepting them
interface video_cfg_scheduler_if #(
  parameter int NCORE = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
);

  localparam int CW = $clog2(NCORE);

  logic          host_valid;
  logic          host_ready;
  logic [CW-1:0] host_core;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;

  modport master (
    output host_valid,
    output host_core,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_core,
    input  host_addr,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/video_cfg_scheduler.sv
// Frame-synchronous configuration scheduler for the video core chain.
//
// Purpose
//   Buffers host register writes in a FIFO and replays them to the addressed
//   video core only during vertical blanking, so no core's pixel path changes
//   configuration mid-frame. With 'immediate' set, writes are applied as soon
//   as they are queued regardless of blanking.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-low reset
//   host           slave modport of video_cfg_scheduler_if (valid/ready write bus)
//   immediate      in   1: apply queued writes at once, ignore vblank
//   vblank         in   level, high during vertical blanking
//   core_wr_en     out  one-hot write strobe, one bit per core
//   core_wr_addr   out  register address to the cores
//   core_wr_data   out  write data to the cores
//   pending        out  number of entries currently queued
//   frame_applied  out  one-cycle pulse when a batch has fully drained
module video_cfg_scheduler #(
  parameter int NCORE = 4,
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  video_cfg_scheduler_if.slave     host,
  input  logic                     immediate,
  input  logic                     vblank,
  output logic [NCORE-1:0]         core_wr_en,
  output logic [AW-1:0]            core_wr_addr,
  output logic [DW-1:0]            core_wr_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     frame_applied
);

  localparam int CW = $clog2(NCORE);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [CW-1:0] core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] batch;
  logic [PW-1:0] batch_next;
  logic [PW-1:0] remaining;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          done;
  logic          vblank_q;
  logic          vblank_rise;
  state_t        state;
  state_t        state_next;

  // Pointers carry one extra MSB: equal low bits with differing MSBs means full.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign push        = host.host_valid && !full;
  assign head        = mem[rd_ptr[IW-1:0]];
  assign vblank_rise = vblank && !vblank_q;
  assign pending     = count;

  // Ready is purely !full; a pop in the same cycle does not free the slot early.
  assign host.host_ready = !full;

  // Entries left after the final pop of a batch, including a same-cycle push.
  assign remaining = count - PW'(1) + PW'(push);

  // FIFO storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IW-1:0]] <= '{core: host.host_core, addr: host.host_addr, data: host.host_data};
    end
  end

  // FIFO pointers, scheduler state, batch counter and the vblank edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      batch    <= '0;
      vblank_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      state    <= state_next;
      batch    <= batch_next;
      vblank_q <= vblank;
    end
  end

  // Next-state logic. A batch is the number of entries queued when draining
  // starts; anything pushed while draining belongs to the next batch.
  always_comb begin
    state_next = state;
    batch_next = batch;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Looking at the incoming push saves a cycle in immediate mode and
        // means a vblank rise right after the first push is not missed.
        if (!empty || push) begin
          if (immediate) begin
            state_next = DRAIN;
            batch_next = count + PW'(push);
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (empty) begin
          state_next = IDLE;
        end else if (immediate || vblank_rise) begin
          state_next = DRAIN;
          batch_next = count;
        end
      end
      DRAIN: begin
        // Blanking ended before the batch finished: stop without a pulse and
        // leave the rest queued, in order, for the next blanking interval.
        if (!immediate && !vblank) begin
          state_next = WAIT;
        end else begin
          pop        = 1'b1;
          batch_next = batch - PW'(1);
          if (batch == PW'(1)) begin
            done = 1'b1;
            if (remaining == '0) begin
              state_next = IDLE;
            end else if (immediate) begin
              state_next = DRAIN;
              batch_next = remaining;
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        batch_next = '0;
      end
    endcase
  end

  // Registered write port to the cores: a pop in cycle N strobes in cycle N+1.
  // Entries naming a nonexistent core are consumed silently, and address/data
  // keep their last value whenever no write is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_wr_en    <= '0;
      core_wr_addr  <= '0;
      core_wr_data  <= '0;
      frame_applied <= 1'b0;
    end else begin
      core_wr_en    <= '0;
      frame_applied <= done;
      if (pop && (32'(head.core) < 32'(NCORE))) begin
        core_wr_en   <= NCORE'(1'b1) << head.core;
        core_wr_addr <= head.addr;
        core_wr_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_video_cfg_scheduler.sv
// Testbench for video_cfg_scheduler.
//
// Purpose
//   Drives directed host writes and vblank patterns into a 4-core scheduler and
//   checks the replayed core writes through an expected-write queue consumed by
//   an independent monitor. A second, 3-core instance exercises writes that
//   name a core that does not exist.
module tb_video_cfg_scheduler;

  localparam int NCORE = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [NCORE-1:0] en;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   immediate;
  logic                   vblank;
  logic [NCORE-1:0]       core_wr_en;
  logic [AW-1:0]          core_wr_addr;
  logic [DW-1:0]          core_wr_data;
  logic [$clog2(DEPTH):0] pending;
  logic                   frame_applied;

  logic [2:0]             en3;
  logic [AW-1:0]          addr3;
  logic [DW-1:0]          data3;
  logic [$clog2(DEPTH):0] pending3;
  logic                   frame_applied3;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   strobes = 0;
  int   frames  = 0;
  int   strobes3 = 0;

  video_cfg_scheduler_if #(.NCORE(NCORE), .AW(AW), .DW(DW)) host_if ();
  video_cfg_scheduler_if #(.NCORE(3),     .AW(AW), .DW(DW)) host3_if ();

  video_cfg_scheduler #(.NCORE(NCORE), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (host_if),
    .immediate     (immediate),
    .vblank        (vblank),
    .core_wr_en    (core_wr_en),
    .core_wr_addr  (core_wr_addr),
    .core_wr_data  (core_wr_data),
    .pending       (pending),
    .frame_applied (frame_applied)
  );

  video_cfg_scheduler #(.NCORE(3), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut3 (
    .clk           (clk),
    .rst           (rst),
    .host          (host3_if),
    .immediate     (1'b1),
    .vblank        (1'b0),
    .core_wr_en    (en3),
    .core_wr_addr  (addr3),
    .core_wr_data  (data3),
    .pending       (pending3),
    .frame_applied (frame_applied3)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issues one host write and records the core write it should produce.
  task automatic apply_stimulus(input logic [1:0] core, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input bit expect_write);
    int   n;
    exp_t e;
    @(negedge clk);
    host_if.host_valid = 1'b1;
    host_if.host_core  = core;
    host_if.host_addr  = addr;
    host_if.host_data  = data;
    if (expect_write) begin
      e.en   = 4'b0001 << core;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
    n = 0;
    while (!host_if.host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!host_if.host_ready) begin
      check_output("push_timeout_ready", host_if.host_ready, 1);
      host_if.host_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 host_if.host_valid = 1'b0;
    end
  endtask

  // Monitor: every strobe consumes the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rst && core_wr_en != '0) begin
      strobes++;
      check_output("strobe_onehot", $onehot(core_wr_en), 1);
      if (sb.size() == 0) begin
        check_output("unexpected_strobe", core_wr_en, 0);
      end else begin
        e = sb.pop_front();
        check_output("sb_en",   core_wr_en,   e.en);
        check_output("sb_addr", core_wr_addr, e.addr);
        check_output("sb_data", core_wr_data, e.data);
      end
    end
    if (rst && frame_applied) frames++;
    if (rst && en3 != '0) strobes3++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int f0;
    rst       = 1'b0;
    immediate = 1'b0;
    vblank    = 1'b0;
    host_if.host_valid  = 1'b0;
    host_if.host_core   = '0;
    host_if.host_addr   = '0;
    host_if.host_data   = '0;
    host3_if.host_valid = 1'b0;
    host3_if.host_core  = '0;
    host3_if.host_addr  = '0;
    host3_if.host_data  = '0;
    wait_cycles(3);
    rst = 1'b1;

    $display("[TB] reset state");
    check_output("rst_ready",   host_if.host_ready, 1);
    check_output("rst_pending", pending, 0);
    check_output("rst_en",      core_wr_en, 0);
    check_output("rst_addr",    core_wr_addr, 0);
    check_output("rst_data",    core_wr_data, 0);
    check_output("rst_frame",   frame_applied, 0);

    $display("[TB] writes held until vblank rises");
    apply_stimulus(2'd0, 8'h10, 32'h0000_000A, 1'b1);
    apply_stimulus(2'd2, 8'h20, 32'h0000_000B, 1'b1);
    apply_stimulus(2'd1, 8'h04, 32'h0000_000C, 1'b1);
    wait_cycles(5);
    check_output("t1_no_strobe", strobes, 0);
    check_output("t1_pending3",  pending, 3);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    check_output("t1_plus1_en", core_wr_en, 4'b0000);
    @(negedge clk);
    check_output("t1_plus2_en", core_wr_en, 4'b0001);
    @(negedge clk);
    check_output("t1_plus3_en", core_wr_en, 4'b0100);
    @(negedge clk);
    check_output("t1_plus4_en",    core_wr_en, 4'b0010);
    check_output("t1_plus4_frame", frame_applied, 1);
    @(negedge clk);
    check_output("t1_pending0", pending, 0);
    check_output("t1_frame_end", frame_applied, 0);
    vblank = 1'b0;
    wait_cycles(2);

    $display("[TB] full FIFO backpressure");
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(2'(i), 8'(8'h40 + i), 32'h1000 + 32'(i), 1'b1);
    end
    @(negedge clk);
    check_output("t2_pending_full", pending, DEPTH);
    check_output("t2_ready_low",    host_if.host_ready, 0);
    s0 = strobes;
    f0 = frames;
    fork
      apply_stimulus(2'd1, 8'h99, 32'h9999_9999, 1'b1);
      begin
        wait_cycles(3);
        check_output("t2_ninth_held", pending, DEPTH);
        vblank = 1'b1;
        wait_cycles(14);
        check_output("t2_strobes8", strobes - s0, 8);
        check_output("t2_frame1",   frames - f0, 1);
        check_output("t2_ninth_waits", pending, 1);
        vblank = 1'b0;
      end
    join
    wait_cycles(2);
    vblank = 1'b1;
    wait_cycles(5);
    check_output("t2_ninth_applied", strobes - s0, 9);
    check_output("t2_frame2",        frames - f0, 2);
    check_output("t2_pending0",      pending, 0);
    vblank = 1'b0;
    wait_cycles(2);

    $display("[TB] blanking ends mid-batch");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2'(i), 8'(8'h30 + i), 32'h3000 + 32'(i), 1'b1);
    end
    s0 = strobes;
    f0 = frames;
    @(negedge clk);
    vblank = 1'b1;
    wait_cycles(4);
    vblank = 1'b0;
    wait_cycles(4);
    check_output("t3_strobes3",   strobes - s0, 3);
    check_output("t3_no_frame",   frames - f0, 0);
    check_output("t3_pending2",   pending, 2);
    check_output("t3_sb_left2",   sb.size(), 2);
    @(negedge clk);
    vblank = 1'b1;
    wait_cycles(6);
    check_output("t3_strobes5",   strobes - s0, 5);
    check_output("t3_frame1",     frames - f0, 1);
    check_output("t3_pending0",   pending, 0);
    vblank = 1'b0;
    wait_cycles(2);

    $display("[TB] immediate mode");
    @(negedge clk);
    immediate = 1'b1;
    apply_stimulus(2'd3, 8'h08, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check_output("t4_plus1_en", core_wr_en, 4'b0000);
    @(negedge clk);
    check_output("t4_en",   core_wr_en, 4'b1000);
    check_output("t4_addr", core_wr_addr, 8'h08);
    check_output("t4_data", core_wr_data, 32'hDEAD_BEEF);
    apply_stimulus(2'd0, 8'h51, 32'h5100_0001, 1'b1);
    apply_stimulus(2'd1, 8'h52, 32'h5200_0002, 1'b1);
    apply_stimulus(2'd2, 8'h53, 32'h5300_0003, 1'b1);
    wait_cycles(6);
    check_output("t4_pending0", pending, 0);
    check_output("t4_sb_empty", sb.size(), 0);
    @(negedge clk);
    immediate = 1'b0;

    $display("[TB] write to nonexistent core is dropped");
    host3_if.host_valid = 1'b1;
    host3_if.host_core  = 2'd3;
    host3_if.host_addr  = 8'h55;
    host3_if.host_data  = 32'h5555_5555;
    check_output("t4b_ready", host3_if.host_ready, 1);
    @(posedge clk);
    #1 host3_if.host_valid = 1'b0;
    @(negedge clk);
    check_output("t4b_pending1", pending3, 1);
    @(negedge clk);
    check_output("t4b_pending0", pending3, 0);
    check_output("t4b_no_en",    en3, 3'b000);
    wait_cycles(3);
    check_output("t4b_no_strobes", strobes3, 0);
    host3_if.host_valid = 1'b1;
    host3_if.host_core  = 2'd2;
    host3_if.host_addr  = 8'h66;
    host3_if.host_data  = 32'h6666_6666;
    @(posedge clk);
    #1 host3_if.host_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("t4b_valid_en",   en3, 3'b100);
    check_output("t4b_valid_addr", addr3, 8'h66);

    $display("[TB] reset during drain");
    apply_stimulus(2'd0, 8'h70, 32'h7000_0000, 1'b1);
    apply_stimulus(2'd1, 8'h71, 32'h7100_0001, 1'b0);
    apply_stimulus(2'd2, 8'h72, 32'h7200_0002, 1'b0);
    apply_stimulus(2'd3, 8'h73, 32'h7300_0003, 1'b0);
    wait_cycles(2);
    @(negedge clk);
    vblank = 1'b1;
    wait_cycles(2);
    check_output("t5_first_strobe", core_wr_en, 4'b0001);
    #2 rst = 1'b0;
    #1;
    check_output("t5_en_cleared", core_wr_en, 0);
    check_output("t5_pending0",   pending, 0);
    check_output("t5_ready",      host_if.host_ready, 1);
    vblank = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(3);
    check_output("t5_pending_after", pending, 0);
    s0 = strobes;
    @(negedge clk);
    vblank = 1'b1;
    wait_cycles(6);
    check_output("t5_no_strobe", strobes - s0, 0);
    vblank = 1'b0;
    wait_cycles(2);

    check_output("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
